id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
ID/EX pipeline register sitting directly downstream of the integer register file. Captures the S/T operands, immediate, register addresses and decode controls each cycle, and presents them to the EX stage. Contains load-use hazard detection: inserts a one-cycle bubble and holds IF/ID when the instruction in EX is a load whose destination is a source of the instruction in ID. Honours downstream stall and branch flush.

Parameters:
CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through
CNT_W, 16, width of stall-cycle counter (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
stall_in  in  1  downstream hold (e.g. multicycle EX/MEM busy)
flush  in  1  branch/jump taken; kill instruction entering EX
id_valid  in  1  ID slot holds a real instruction
id_S  in  32  rs operand from register file
id_T  in  32  rt operand from register file
id_imm  in  32  sign/zero-extended immediate
id_rs  in  5  rs address
id_rt  in  5  rt address
id_wa  in  5  destination address (rd or rt, already selected)
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes a register
id_ctrl  in  CTRL_W  remaining controls, pass-through
ex_valid  out  1  EX slot holds a real instruction
ex_S, ex_T, ex_imm  out  32 each  registered operands
ex_rs, ex_rt, ex_wa  out  5 each  registered addresses
ex_mem_read, ex_reg_write  out  1 each  registered controls
ex_ctrl  out  CTRL_W  registered control bundle
hold_if_id  out  1  combinational; PC and IF/ID must not advance
stall_count  out  CNT_W  only when STALL_CNT_EN defined

Behaviour:
- Reset (rst=1 at clk edge): all ex_* outputs = 0, ex_valid = 0. hold_if_id = 0 while rst=1.
- Latency: 1 cycle, ID inputs at edge N appear on ex_* after edge N.
- Hazard (combinational): haz = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_wa != 0) & ((id_use_rs & ex_wa == id_rs) | (id_use_rt & ex_wa == id_rt)).
- Per-edge action, priority order:
  1. rst: clear as above.
  2. flush: ex_valid, ex_mem_read, ex_reg_write, ex_wa, ex_ctrl <= 0; data fields <= 0. Flush wins over stall_in and haz.
  3. stall_in: all ex_* hold current values.
  4. haz: insert bubble (clear as in flush).
  5. else: load all ex_* from id_*; ex_valid <= id_valid; if id_valid = 0, control fields loaded as 0.
- hold_if_id = ~rst & ~flush & (stall_in | haz).
- Load-use bubble lasts exactly one cycle: after bubble ex_valid = 0, so haz deasserts and the held instruction loads next cycle.
- Destination $0 never causes a hazard.
- Back-to-back loads with chained dependency: each dependent instruction gets exactly one bubble.
- rst asserted mid-stall or mid-bubble: clears immediately; no pending state survives.
- No internal FSM state beyond the pipeline registers (and optional counter).

Optional Feature:
STALL_CNT_EN: when defined, adds stall_count, CNT_W-bit counter, 0 on reset, +1 on every edge where hold_if_id = 1, saturates at all-ones (no wrap). When undefined, the port and counter are absent; all other behaviour identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with id_valid=1, id_S=32'hDEAD_BEEF -> all ex_* = 0, hold_if_id = 0.
- Pass-through: id_S=32'h0000_0005, id_T=32'h0000_0007, id_wa=3, id_reg_write=1 -> ex_S=5, ex_T=7, ex_wa=3, ex_valid=1 one edge later.
- Load-use: lw $8 in EX (ex_mem_read=1, ex_wa=8), ID add with id_rs=8, id_use_rs=1 -> hold_if_id=1 for one cycle, ex_valid=0 next edge, add enters EX the following edge; with STALL_CNT_EN stall_count=1.
- No false hazard: lw to $0 in EX, ID id_rs=0 -> hold_if_id=0, no bubble; id_use_rt=0 and id_rt=8 with ex_wa=8 -> no bubble.
- stall_in=1 for 3 cycles with changing id_* -> ex_* frozen, hold_if_id=1 each cycle; stall_count=3.
- flush=1 with stall_in=1 and hazard active simultaneously -> ex_valid=0, ex_reg_write=0 next edge, hold_if_id=0.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline interface: ID-side instruction fields in, EX-side registered
// fields out, plus downstream stall, branch flush and the IF/ID hold request.
// Optional build macro: STALL_CNT_EN adds the stall_count signal and the
// CNT_W parameter that sizes it.
//
// Handshake semantics: ex_valid qualifies the EX slot (a zero means bubble);
// id_valid qualifies the ID slot. hold_if_id is the only back-pressure toward
// IF/ID: while it is high, the ID slot must present the same instruction on
// the next cycle because it has not been accepted into EX. stall_in is
// back-pressure from EX/MEM and freezes the EX slot; flush kills whatever
// would enter EX and overrides both stall_in and the load-use hazard.
interface id_ex_pipe_if #(
  parameter int CTRL_W = 8
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
);

  // Pipeline control
  logic              stall_in;
  logic              flush;
  logic              hold_if_id;

  // ID-side instruction fields
  logic              id_valid;
  logic [31:0]       id_S;
  logic [31:0]       id_T;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_wa;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_mem_read;
  logic              id_reg_write;
  logic [CTRL_W-1:0] id_ctrl;

  // EX-side registered fields
  logic              ex_valid;
  logic [31:0]       ex_S;
  logic [31:0]       ex_T;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_wa;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [CTRL_W-1:0] ex_ctrl;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0]  stall_count;
`endif

  // Upstream/environment side: drives ID fields and pipeline control
  modport master (
    output stall_in, flush,
    output id_valid, id_S, id_T, id_imm, id_rs, id_rt, id_wa,
    output id_use_rs, id_use_rt, id_mem_read, id_reg_write, id_ctrl,
    input  ex_valid, ex_S, ex_T, ex_imm, ex_rs, ex_rt, ex_wa,
    input  ex_mem_read, ex_reg_write, ex_ctrl,
    input  hold_if_id
`ifdef STALL_CNT_EN
    , input stall_count
`endif
  );

  // Pipeline register side
  modport slave (
    input  stall_in, flush,
    input  id_valid, id_S, id_T, id_imm, id_rs, id_rt, id_wa,
    input  id_use_rs, id_use_rt, id_mem_read, id_reg_write, id_ctrl,
    output ex_valid, ex_S, ex_T, ex_imm, ex_rs, ex_rt, ex_wa,
    output ex_mem_read, ex_reg_write, ex_ctrl,
    output hold_if_id
`ifdef STALL_CNT_EN
    , output stall_count
`endif
  );

endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures register-file operands, immediate, addresses and decode controls
// and presents them to EX one cycle later. A load in EX whose destination is
// read by the instruction in ID causes a single bubble and holds IF/ID.
// Per-edge priority: rst > flush > stall_in > hazard bubble > load.
// Optional build macro: STALL_CNT_EN adds a saturating count of cycles in
// which hold_if_id was asserted.
module id_ex_pipe #(
  parameter int CTRL_W = 8
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  id_ex_pipe_if.slave bus
);

  // Contents of the EX slot. Control fields (valid, mem_read, reg_write, wa,
  // ctrl) are the ones that must be zero for a bubble to be harmless.
  typedef struct packed {
    logic              valid;
    logic [31:0]       s;
    logic [31:0]       t;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wa;
    logic              mem_read;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t ex_q;
  ex_slot_t ex_d;
  ex_slot_t id_slot;

  logic haz;
  logic hold;
  logic rs_match;
  logic rt_match;

  // Load-use hazard: a valid writing load in EX targets a register the ID
  // instruction actually reads. Register $0 is hardwired and never conflicts.
  always_comb begin
    rs_match = bus.id_use_rs & (ex_q.wa == bus.id_rs);
    rt_match = bus.id_use_rt & (ex_q.wa == bus.id_rt);
    haz      = bus.id_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
               (ex_q.wa != 5'd0) & (rs_match | rt_match);
    hold     = ~rst & ~bus.flush & (bus.stall_in | haz);
  end

  // Build the slot that would be loaded from ID; an invalid ID slot carries
  // zeroed controls so it can never write or trigger a hazard downstream.
  always_comb begin
    id_slot.valid     = bus.id_valid;
    id_slot.s         = bus.id_S;
    id_slot.t         = bus.id_T;
    id_slot.imm       = bus.id_imm;
    id_slot.rs        = bus.id_rs;
    id_slot.rt        = bus.id_rt;
    id_slot.wa        = bus.id_valid ? bus.id_wa : 5'd0;
    id_slot.mem_read  = bus.id_valid & bus.id_mem_read;
    id_slot.reg_write = bus.id_valid & bus.id_reg_write;
    id_slot.ctrl      = bus.id_valid ? bus.id_ctrl : '0;
  end

  // Next EX slot: flush and hazard both insert an all-zero bubble, stall
  // freezes, otherwise ID advances. Reset is applied in the register process.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall_in) begin
      ex_d = ex_q;
    end else if (haz) begin
      ex_d = '0;
    end else begin
      ex_d = id_slot;
    end
  end

  // EX slot register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.hold_if_id   = hold;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_S         = ex_q.s;
  assign bus.ex_T         = ex_q.t;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_wa        = ex_q.wa;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_ctrl      = ex_q.ctrl;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Saturating count of held cycles; sticks at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Testbench for id_ex_pipe: directed scenarios followed by randomized traffic,
// checked by a scoreboard fed from a reference model of the EX slot.
module tb_id_ex_pipe;

  localparam int CTRL_W = 8;
`ifdef STALL_CNT_EN
  localparam int CNT_W = 16;
`endif
  localparam int EW = 1 + 96 + 15 + 2 + CTRL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipe_if #(
    .CTRL_W(CTRL_W)
`ifdef STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  id_ex_pipe #(
    .CTRL_W(CTRL_W)
`ifdef STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic          hold_q[$];
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q[$];
  logic [CNT_W-1:0] m_cnt;
`endif
  int tests = 0;
  int fails = 0;

  // Reference model: what the EX stage should be holding
  logic              m_valid;
  logic [31:0]       m_s, m_t, m_imm;
  logic [4:0]        m_rs, m_rt, m_wa;
  logic              m_mr, m_rw;
  logic [CTRL_W-1:0] m_ctrl;

  function automatic logic [EW-1:0] model_vec();
    return {m_valid, m_s, m_t, m_imm, m_rs, m_rt, m_wa, m_mr, m_rw, m_ctrl};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_s = 0; m_t = 0; m_imm = 0; m_rs = 0; m_rt = 0;
    m_wa = 0; m_mr = 0; m_rw = 0; m_ctrl = 0;
  endtask

  // Apply the pipeline rules for the coming edge to the current inputs
  task automatic model_step();
    bit reads_ex_dest;
    bit load_use;
    bit exp_hold;
    reads_ex_dest = (bus.id_use_rs && bus.id_rs == m_wa) ||
                    (bus.id_use_rt && bus.id_rt == m_wa);
    load_use = bus.id_valid && m_valid && m_mr && m_rw && (m_wa != 0) && reads_ex_dest;
    exp_hold = !rst && !bus.flush && (bus.stall_in || load_use);
    hold_q.push_back(exp_hold);
`ifdef STALL_CNT_EN
    if (rst) m_cnt = 0;
    else if (exp_hold && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
    cnt_q.push_back(m_cnt);
`endif
    if (rst || bus.flush) begin
      model_clear();
    end else if (bus.stall_in) begin
      // EX keeps what it has
    end else if (load_use) begin
      model_clear();
    end else if (bus.id_valid) begin
      m_valid = 1; m_s = bus.id_S; m_t = bus.id_T; m_imm = bus.id_imm;
      m_rs = bus.id_rs; m_rt = bus.id_rt; m_wa = bus.id_wa;
      m_mr = bus.id_mem_read; m_rw = bus.id_reg_write; m_ctrl = bus.id_ctrl;
    end else begin
      m_valid = 0; m_s = bus.id_S; m_t = bus.id_T; m_imm = bus.id_imm;
      m_rs = bus.id_rs; m_rt = bus.id_rt; m_wa = 0;
      m_mr = 0; m_rw = 0; m_ctrl = 0;
    end
    exp_q.push_back(model_vec());
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ctl(input logic r, input logic f, input logic s);
    rst = r;
    bus.flush = f;
    bus.stall_in = s;
  endtask

  task automatic set_id(input logic v, input logic [31:0] s, input logic [31:0] t,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wa, input logic urs, input logic urt,
                        input logic mr, input logic rw, input logic [CTRL_W-1:0] c);
    bus.id_valid = v; bus.id_S = s; bus.id_T = t; bus.id_imm = imm;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_wa = wa;
    bus.id_use_rs = urs; bus.id_use_rt = urt;
    bus.id_mem_read = mr; bus.id_reg_write = rw; bus.id_ctrl = c;
  endtask

  task automatic set_id_random();
    set_id(1'($urandom_range(0, 9) != 0), $urandom, $urandom, $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CTRL_W'($urandom));
  endtask

  // Inputs are set at a falling edge; the model records expectations, then
  // the task waits for the next falling edge.
  task automatic step();
    #1;
    model_step();
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic          h;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] ec;
`endif
    forever begin
      @(negedge clk);
      #2;
      if (hold_q.size() > 0) begin
        h = hold_q.pop_front();
        tests++;
        if (bus.hold_if_id !== h) begin
          fails++;
          $display("FAIL hold_if_id at %0t: got %b expected %b", $time, bus.hold_if_id, h);
        end
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({bus.ex_valid, bus.ex_S, bus.ex_T, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_wa,
             bus.ex_mem_read, bus.ex_reg_write, bus.ex_ctrl} !== e) begin
          fails++;
          $display("FAIL ex_slot at %0t: got v=%b S=%h T=%h imm=%h rs=%0d rt=%0d wa=%0d mr=%b rw=%b c=%h expected %h",
                   $time, bus.ex_valid, bus.ex_S, bus.ex_T, bus.ex_imm, bus.ex_rs, bus.ex_rt,
                   bus.ex_wa, bus.ex_mem_read, bus.ex_reg_write, bus.ex_ctrl, e);
        end
      end
`ifdef STALL_CNT_EN
      if (cnt_q.size() > 0) begin
        ec = cnt_q.pop_front();
        tests++;
        if (bus.stall_count !== ec) begin
          fails++;
          $display("FAIL stall_count at %0t: got %0d expected %0d", $time, bus.stall_count, ec);
        end
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
`ifdef STALL_CNT_EN
    m_cnt = 0;
`endif
    set_ctl(1, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset with a live instruction presented
    set_id(1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h9, 5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 8'hFF);
    step();
    step();
    set_ctl(0, 0, 0);

    // Plain pass-through
    set_id(1, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 8'h11);
    step();

    // Load-use: lw $8 then add reading $8 -> one bubble, then add enters
    set_id(1, 32'h100, 32'h0, 32'h4, 5'd2, 5'd0, 5'd8, 1, 0, 1, 1, 8'h22);
    step();
    set_id(1, 32'h1, 32'h2, 32'h0, 5'd8, 5'd3, 5'd9, 1, 1, 0, 1, 8'h33);
    step();
    step();

    // Load to $0 never stalls a reader of $0
    set_id(1, 32'h40, 32'h0, 32'h8, 5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 8'h44);
    step();
    set_id(1, 32'h3, 32'h4, 32'h0, 5'd0, 5'd0, 5'd4, 1, 1, 0, 1, 8'h55);
    step();

    // rt matches the load destination but is not read -> no bubble
    set_id(1, 32'h80, 32'h0, 32'hC, 5'd2, 5'd0, 5'd8, 1, 0, 1, 1, 8'h66);
    step();
    set_id(1, 32'h6, 32'h7, 32'h0, 5'd1, 5'd8, 5'd5, 1, 0, 0, 1, 8'h77);
    step();

    // Downstream stall for three cycles with changing ID fields
    set_ctl(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      set_id_random();
      step();
    end
    set_ctl(0, 0, 0);
    set_id(1, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd6, 1, 1, 0, 1, 8'h88);
    step();

    // Flush together with stall and an active load-use hazard
    set_id(1, 32'h200, 32'h0, 32'h10, 5'd2, 5'd0, 5'd8, 1, 0, 1, 1, 8'h99);
    step();
    set_id(1, 32'h1, 32'h2, 32'h0, 5'd8, 5'd8, 5'd9, 1, 1, 0, 1, 8'hAA);
    set_ctl(0, 1, 1);
    step();
    set_ctl(0, 0, 0);
    step();

    // Back-to-back chained loads: each dependent gets one bubble
    set_id(1, 32'h300, 32'h0, 32'h0, 5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 8'h01);
    step();
    set_id(1, 32'h301, 32'h0, 32'h0, 5'd8, 5'd0, 5'd9, 1, 0, 1, 1, 8'h02);
    step();
    step();
    set_id(1, 32'h302, 32'h0, 32'h0, 5'd3, 5'd9, 5'd10, 0, 1, 0, 1, 8'h03);
    step();
    step();

    // Reset arriving in the middle of a stall and of a bubble
    set_ctl(0, 0, 1);
    step();
    set_ctl(1, 0, 1);
    step();
    set_ctl(0, 0, 0);
    set_id(1, 32'h400, 32'h0, 32'h0, 5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 8'h04);
    step();
    set_id(1, 32'h401, 32'h0, 32'h0, 5'd8, 5'd0, 5'd9, 1, 0, 0, 1, 8'h05);
    set_ctl(1, 0, 0);
    step();
    set_ctl(0, 0, 0);
    step();

    // Randomized traffic with small address space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_ctl(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 10),
              1'($urandom_range(0, 99) < 20));
      set_id_random();
      step();
    end
    set_ctl(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || hold_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d ex and %0d hold expectations left unchecked, required 0",
               exp_q.size(), hold_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
